// File: rtl/ipic_lite_arbiter_pkg.sv
// Shared definitions for the IPIC-lite register-access arbiter:
// op codes, arbiter state encoding and the ath9k MAC base address.
package ipic_lite_pkg;

   localparam logic [2:0]  IPIC_SINGLE_RD  = 3'd2;
   localparam logic [2:0]  IPIC_SINGLE_WR  = 3'd3;
   localparam logic [31:0] ATH9K_BASE_ADDR = 32'h6000_0000;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_START,
      ST_WAIT,
      ST_RESP
   } arb_state_e;

   function automatic logic is_legal_op(input logic [2:0] op);
      return (op == IPIC_SINGLE_RD) || (op == IPIC_SINGLE_WR);
   endfunction

endpackage

// File: rtl/ipic_lite_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester above ptr_i,
// wrapping modulo NUM_REQ; returns a one-hot grant and its index.
module rr_pick #(
   parameter int NUM_REQ = 3,
   parameter int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [IDX_W-1:0]   ptr_i,
   output logic [NUM_REQ-1:0] gnt_o,
   output logic [IDX_W-1:0]   idx_o
);

   logic found;
   int   c;

   always_comb begin
      gnt_o = '0;
      idx_o = '0;
      found = 1'b0;
      c     = 0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         c = (int'(ptr_i) + i) % NUM_REQ;
         if (!found && req_i[c]) begin
            found    = 1'b1;
            gnt_o[c] = 1'b1;
            idx_o    = IDX_W'(c);
         end
      end
   end

endmodule

// File: rtl/ipic_lite_arbiter.sv
// Round-robin arbiter sharing the IPIC-lite register master among clients.
// Define IPIC_ARB_TIMEOUT_EN to enable the WAIT-state watchdog.
module ipic_lite_arbiter
   import ipic_lite_pkg::*;
#(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int NUM_REQ        = 3,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [NUM_REQ-1:0]         req_valid,
   input  logic [3*NUM_REQ-1:0]       req_type,
   input  logic [ADDR_WIDTH*NUM_REQ-1:0] req_addr,
   input  logic [DATA_WIDTH*NUM_REQ-1:0] req_wdata,
   output logic [NUM_REQ-1:0]         req_ack,
   output logic [NUM_REQ-1:0]         resp_done,
   output logic                       resp_err,
   output logic [DATA_WIDTH-1:0]      resp_rdata,
   input  logic [3:0]                 curr_ipic_lite_state,
   output logic [2:0]                 ipic_type_lite,
   output logic                       ipic_start_lite,
   input  logic                       ipic_done_lite_wire,
   output logic [ADDR_WIDTH-1:0]      read_addr_lite,
   output logic [ADDR_WIDTH-1:0]      write_addr_lite,
   output logic [DATA_WIDTH-1:0]      write_data_lite,
   input  logic [DATA_WIDTH-1:0]      single_read_data_lite,
   output logic                       timeout_flag
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   arb_state_e              state_q;
   logic [IDX_W-1:0]        rr_ptr_q;
   logic [NUM_REQ-1:0]      owner_q;
   logic [NUM_REQ-1:0]      req_ack_q;
   logic [NUM_REQ-1:0]      resp_done_q;
   logic                    resp_err_q;
   logic [DATA_WIDTH-1:0]   resp_rdata_q;
   logic [2:0]              ipic_type_q;
   logic                    ipic_start_q;
   logic [ADDR_WIDTH-1:0]   read_addr_q;
   logic [ADDR_WIDTH-1:0]   write_addr_q;
   logic [DATA_WIDTH-1:0]   write_data_q;

   logic [2:0]              typ_a   [NUM_REQ];
   logic [ADDR_WIDTH-1:0]   addr_a  [NUM_REQ];
   logic [DATA_WIDTH-1:0]   wdata_a [NUM_REQ];
   logic [NUM_REQ-1:0]      win_gnt;
   logic [IDX_W-1:0]        win_idx;
   logic                    arb_go;

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
      assign typ_a[g]   = req_type[3*g +: 3];
      assign addr_a[g]  = req_addr[ADDR_WIDTH*g +: ADDR_WIDTH];
      assign wdata_a[g] = req_wdata[DATA_WIDTH*g +: DATA_WIDTH];
   end

   rr_pick #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_rr_pick (
      .req_i (req_valid),
      .ptr_i (rr_ptr_q),
      .gnt_o (win_gnt),
      .idx_o (win_idx)
   );

   assign arb_go = (|req_valid) && (curr_ipic_lite_state == 4'd0);

`ifdef IPIC_ARB_TIMEOUT_EN
   localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
   logic [15:0] wd_cnt_q;
   logic        timeout_q;
`else
   logic unused_cfg;
   assign unused_cfg = (TIMEOUT_CYCLES == 0);
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         rr_ptr_q     <= IDX_W'(NUM_REQ - 1);
         owner_q      <= '0;
         req_ack_q    <= '0;
         resp_done_q  <= '0;
         resp_err_q   <= 1'b0;
         resp_rdata_q <= '0;
         ipic_type_q  <= '0;
         ipic_start_q <= 1'b0;
         read_addr_q  <= '0;
         write_addr_q <= '0;
         write_data_q <= '0;
`ifdef IPIC_ARB_TIMEOUT_EN
         wd_cnt_q     <= '0;
         timeout_q    <= 1'b0;
`endif
      end else begin
         req_ack_q    <= '0;
         resp_done_q  <= '0;
         ipic_start_q <= 1'b0;
`ifdef IPIC_ARB_TIMEOUT_EN
         if (state_q != ST_WAIT) wd_cnt_q <= '0;
`endif
         unique case (state_q)
            ST_IDLE: begin
               if (arb_go) begin
                  req_ack_q <= win_gnt;
                  owner_q   <= win_gnt;
                  rr_ptr_q  <= win_idx;
                  if (is_legal_op(typ_a[win_idx])) begin
                     ipic_type_q  <= typ_a[win_idx];
                     read_addr_q  <= addr_a[win_idx];
                     write_addr_q <= addr_a[win_idx];
                     write_data_q <= wdata_a[win_idx];
                     ipic_start_q <= 1'b1;
                     state_q      <= ST_START;
                  end else begin
                     state_q <= ST_RESP;
                  end
               end
            end
            ST_START: state_q <= ST_WAIT;
            ST_WAIT: begin
               if (ipic_done_lite_wire) begin
                  resp_done_q  <= owner_q;
                  resp_err_q   <= 1'b0;
                  resp_rdata_q <= (ipic_type_q == IPIC_SINGLE_RD) ?
                                  single_read_data_lite : '0;
                  state_q      <= ST_IDLE;
`ifdef IPIC_ARB_TIMEOUT_EN
                  wd_cnt_q     <= '0;
               end else if (wd_cnt_q == TO_LAST) begin
                  resp_done_q  <= owner_q;
                  resp_err_q   <= 1'b1;
                  resp_rdata_q <= DATA_WIDTH'(32'hDEAD_BEEF);
                  timeout_q    <= 1'b1;
                  wd_cnt_q     <= '0;
                  state_q      <= ST_IDLE;
               end else begin
                  wd_cnt_q <= wd_cnt_q + 16'd1;
`endif
               end
            end
            ST_RESP: begin
               resp_done_q  <= owner_q;
               resp_err_q   <= 1'b1;
               resp_rdata_q <= '0;
               state_q      <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign req_ack         = req_ack_q;
   assign resp_done       = resp_done_q;
   assign resp_err        = resp_err_q;
   assign resp_rdata      = resp_rdata_q;
   assign ipic_type_lite  = ipic_type_q;
   assign ipic_start_lite = ipic_start_q;
   assign read_addr_lite  = read_addr_q;
   assign write_addr_lite = write_addr_q;
   assign write_data_lite = write_data_q;
`ifdef IPIC_ARB_TIMEOUT_EN
   assign timeout_flag    = timeout_q;
`else
   assign timeout_flag    = 1'b0;
`endif

endmodule
